uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1/9600 receiver in the programming loader path.
- Generalised in clock rate, baud, data width, stop bits; optional parity.
- Adds input synchronisation, mid-bit sampling, false-start rejection, framing-error detection and a one-cycle VALID strobe.
- Sits between the board RXD pin and the program-load / debug byte consumers.

Parameters:
CLK_HZ, 48000000, system clock frequency in Hz
BAUD, 9600, line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
DATA_BITS, 8, data bits per frame, legal 5..9, LSB received first
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
RXD  input  1  asynchronous serial line, idle high
DATA  output  DATA_BITS  last received word, held until next frame completes
VALID  output  1  one-cycle strobe: DATA updated this cycle
FRAME_ERR  output  1  one-cycle strobe with VALID when any stop bit sampled 0
PARITY_ERR  output  1  one-cycle strobe with VALID on parity mismatch (constant 0 without macro)
IDLE  output  1  high when in IDLE state

Behaviour:
- Reset: DATA=0, VALID=FRAME_ERR=PARITY_ERR=0, IDLE=1, state IDLE, counters 0, both synchroniser flops=1.
- RXD passes a 2-flop synchroniser -> rxs; all decisions use rxs and a registered copy rxs_d.
- bit counter: $clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1; reset to 0 on every state change.
- IDLE: start detected only on rxs_d=1, rxs=0 (falling edge). Line held low across reset release is not a start until it returns high. -> START.
- START: at count CLKS_PER_BIT/2-1 sample rxs. If 0 -> DATA; if 1 -> IDLE (false start, no strobes).
- DATA: sample every CLKS_PER_BIT cycles; shift into shadow register LSB-first. After DATA_BITS samples -> PARITY if enabled, else STOP.
- STOP: sample each stop bit after CLKS_PER_BIT. Last stop sample: copy shadow to DATA, pulse VALID. If any stop sample was 0, pulse FRAME_ERR.
- STOP exit, all stop samples 1: -> IDLE immediately (mid stop bit), allowing back-to-back frames.
- STOP exit, last stop sample 0: -> BREAK.
- BREAK: wait for rxs=1, then -> IDLE. No further strobes during a held-low line.
- Latency: VALID high (2 + CLKS_PER_BIT/2 + (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT) cycles after the first CLK edge sampling RXD low, where P = 1 with parity, else 0. The bench checks this to ±1 cycle.
- RST asserted mid-frame: abort immediately, return to reset values, no strobe for the partial frame.
- VALID, FRAME_ERR and PARITY_ERR are never high outside the single completion cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state after DATA samples one parity bit.
  - Module-local parameter PARITY_ODD, default 0 (even).
  - PARITY_ERR pulses with VALID when received parity mismatches the XOR of the data bits (inverted for odd). DATA is still delivered.
- Undefined:
  - No PARITY state; frame is start + DATA_BITS + STOP_BITS.
  - PARITY_ERR tied 0.

Test Plan:
- Config CLK_HZ=16, BAUD=1 (16 clks/bit), 8N1; send 0xA5 -> one VALID pulse, DATA=0xA5, FRAME_ERR=0, IDLE low during frame then high.
- RXD low for 4 cycles then high -> no VALID, state back to IDLE by count 7, DATA unchanged.
- Send 0x3C with stop bit 0, then line held low 40 cycles -> VALID+FRAME_ERR once, DATA=0x3C, no second start until RXD high then low.
- Back-to-back 0x00 then 0xFF with no idle gap -> two VALID pulses 160±1 cycles apart, DATA 0x00 then 0xFF.
- UART_RX_PARITY_EN, even: send 0x07 with parity bit 0 -> VALID, PARITY_ERR=1; resend with parity 1 -> PARITY_ERR=0.
- RST for 1 cycle during data bit 4 of 0x55 -> no VALID for that frame, DATA=0; next full frame 0x12 received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, false-start and framing checks.
// Parity checking is compiled in when UART_RX_PARITY_EN is defined (PARITY_ODD selects odd parity).
module uart_rx_param #(
   parameter int CLK_HZ    = 48000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   output logic                 FRAME_ERR,
   output logic                 PARITY_ERR,
   output logic                 IDLE
);

   localparam int CPB = CLK_HZ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int BW  = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                r_state;
   logic                  r_sync1;
   logic                  r_rxs;
   logic                  r_rxs_d;
   logic [1:0]            r_warm;
   logic                  r_armed;
   logic [CW-1:0]         r_cnt;
   logic [BW-1:0]         r_bit;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_stop_err;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_ferr;

   state_t                w_state_nx;
   logic [CW-1:0]         w_cnt_nx;
   logic [BW-1:0]         w_bit_nx;
   logic [DATA_BITS-1:0]  w_shift_nx;
   logic                  w_stop_err_nx;
   logic [DATA_BITS-1:0]  w_data_nx;
   logic                  w_valid_nx;
   logic                  w_ferr_nx;
   logic                  w_cnt_last;
   logic                  w_start_edge;

`ifdef UART_RX_PARITY_EN
   logic                  r_par_bad;
   logic                  r_perr;
   logic                  w_par_bad_nx;
   logic                  w_perr_nx;
`endif

   // r_warm marks when r_rxs holds a real line sample; r_armed then waits for the line to be
   // seen high, so a line held low across reset release never looks like a start edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
         r_rxs_d <= 1'b1;
         r_warm  <= '0;
         r_armed <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge values, which is
         // what makes this chain a shift register rather than a single wire.
         r_sync1 <= RXD;
         r_rxs   <= r_sync1;
         r_rxs_d <= r_rxs;
         r_warm  <= {r_warm[0], 1'b1};
         r_armed <= r_armed | (r_warm[1] & r_rxs);
      end
   end

   assign w_cnt_last   = (r_cnt == CNT_LAST);
   assign w_start_edge = r_armed & r_rxs_d & ~r_rxs;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_state_nx    = r_state;
      w_cnt_nx      = w_cnt_last ? '0 : r_cnt + CW'(1);
      w_bit_nx      = r_bit;
      w_shift_nx    = r_shift;
      w_stop_err_nx = r_stop_err;
      w_data_nx     = r_data;
      w_valid_nx    = 1'b0;
      w_ferr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nx  = r_par_bad;
      w_perr_nx     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_stop_err_nx = 1'b0;
            if (w_start_edge) w_state_nx = S_START;
         end
         S_START: begin
            if (r_cnt == CNT_HALF) w_state_nx = r_rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_cnt_last) begin
               w_shift_nx = {r_rxs, r_shift[DATA_BITS-1:1]};
               w_bit_nx   = r_bit + BW'(1);
               if (r_bit == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nx = S_PARITY;
`else
                  w_state_nx = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_last) begin
               w_par_bad_nx = (^r_shift) ^ r_rxs ^ PARITY_ODD;
               w_state_nx   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_cnt_last) begin
               w_bit_nx = r_bit + BW'(1);
               if (!r_rxs) w_stop_err_nx = 1'b1;
               if (r_bit == STOP_LAST) begin
                  w_data_nx  = r_shift;
                  w_valid_nx = 1'b1;
                  w_ferr_nx  = r_stop_err | ~r_rxs;
`ifdef UART_RX_PARITY_EN
                  w_perr_nx  = r_par_bad;
`endif
                  // Leaving mid stop bit gives the next start edge half a bit of slack.
                  w_state_nx = r_rxs ? S_IDLE : S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (r_rxs) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (w_state_nx != r_state) begin
         w_cnt_nx = '0;
         w_bit_nx = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_stop_err <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_bit      <= w_bit_nx;
         r_shift    <= w_shift_nx;
         r_stop_err <= w_stop_err_nx;
         r_data     <= w_data_nx;
         r_valid    <= w_valid_nx;
         r_ferr     <= w_ferr_nx;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         r_par_bad <= w_par_bad_nx;
         r_perr    <= w_perr_nx;
      end
   end

   assign PARITY_ERR = r_perr;
`else
   assign PARITY_ERR = 1'b0;
`endif

   assign DATA      = r_data;
   assign VALID     = r_valid;
   assign FRAME_ERR = r_ferr;
   assign IDLE      = (r_state == S_IDLE);

endmodule
